// File: rtl/control_pipeline_pkg.sv
// Shared decoder/control constants: opcodes, control-ROM indices, control-field encodings
// and the control-word / W-stage payload types.
package control_pipeline_pkg;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned IMM_W = 3;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned LD_W  = 3;
  localparam int unsigned WE_W  = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [IDX_W-1:0] IDX_AND     = 6'd9;
  localparam logic [IDX_W-1:0] IDX_LB      = 6'd10;
  localparam logic [IDX_W-1:0] IDX_LHU     = 6'd14;
  localparam logic [IDX_W-1:0] IDX_ADDI    = 6'd15;
  localparam logic [IDX_W-1:0] IDX_ANDI    = 6'd23;
  localparam logic [IDX_W-1:0] IDX_LUI     = 6'd24;
  localparam logic [IDX_W-1:0] IDX_AUIPC   = 6'd25;
  localparam logic [IDX_W-1:0] IDX_JAL     = 6'd26;
  localparam logic [IDX_W-1:0] IDX_JALR    = 6'd27;
  localparam logic [IDX_W-1:0] IDX_BR_LO   = 6'd28;
  localparam logic [IDX_W-1:0] IDX_BLTU    = 6'd36;
  localparam logic [IDX_W-1:0] IDX_BR_HI   = 6'd39;
  localparam logic [IDX_W-1:0] IDX_SB      = 6'd40;
  localparam logic [IDX_W-1:0] IDX_SH      = 6'd41;
  localparam logic [IDX_W-1:0] IDX_SW      = 6'd42;
  localparam logic [IDX_W-1:0] IDX_NOP     = 6'd63;

  localparam logic [WB_W-1:0] WB_MEM = 2'd0;
  localparam logic [WB_W-1:0] WB_ALU = 2'd1;
  localparam logic [WB_W-1:0] WB_PC4 = 2'd2;

  localparam logic [LD_W-1:0] LD_NONE = 3'd0;  // lb..lhu follow as 1..5

  localparam logic [IMM_W-1:0] IMM_I = 3'd0;
  localparam logic [IMM_W-1:0] IMM_S = 3'd1;
  localparam logic [IMM_W-1:0] IMM_B = 3'd2;
  localparam logic [IMM_W-1:0] IMM_U = 3'd3;
  localparam logic [IMM_W-1:0] IMM_J = 3'd4;

  // add..and occupy 0..9 in R-type index order; COPYB passes operand B (lui)
  localparam logic [ALU_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_W-1:0] ALU_COPYB = 4'd10;

  typedef struct packed {
    logic             legal;
    logic             redirect;
    logic [ALU_W-1:0] alu_sel;
    logic             a_sel;
    logic             b_sel;
    logic [IMM_W-1:0] imm_sel;
    logic             br_un;
    logic [WE_W-1:0]  mem_we;
    logic             reg_we;
    logic [WB_W-1:0]  wb_sel;
    logic [LD_W-1:0]  ld_type;
  } ctrl_t;

  typedef struct packed {
    logic             valid;
    logic             reg_we;
    logic [WB_W-1:0]  wb_sel;
    logic [LD_W-1:0]  ld_type;
    logic [REG_W-1:0] rd;
    logic             illegal;
  } w_ctrl_t;

endpackage

// File: rtl/control_pipeline_rom.sv
// Control ROM: combinational index -> control word lookup, including the legal flag.
module control_rom
  import control_pipeline_pkg::*;
(
  input  logic [IDX_W-1:0] rom_idx,
  output ctrl_t            ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    if (rom_idx <= IDX_AND) begin
      ctrl_c.legal   = 1'b1;
      ctrl_c.alu_sel = ALU_W'(rom_idx);
      ctrl_c.reg_we  = 1'b1;
      ctrl_c.wb_sel  = WB_ALU;
    end else if (rom_idx <= IDX_LHU) begin
      ctrl_c.legal   = 1'b1;
      ctrl_c.b_sel   = 1'b1;
      ctrl_c.imm_sel = IMM_I;
      ctrl_c.reg_we  = 1'b1;
      ctrl_c.wb_sel  = WB_MEM;
      ctrl_c.ld_type = LD_W'(rom_idx - IDX_LB) + LD_W'(1);
    end else if (rom_idx <= IDX_ANDI) begin
      // slli..andi line up with the R-type ALU codes 2..9
      ctrl_c.legal   = 1'b1;
      ctrl_c.alu_sel = (rom_idx == IDX_ADDI) ? ALU_ADD : ALU_W'(rom_idx - 6'd14);
      ctrl_c.b_sel   = 1'b1;
      ctrl_c.imm_sel = IMM_I;
      ctrl_c.reg_we  = 1'b1;
      ctrl_c.wb_sel  = WB_ALU;
    end else if (rom_idx == IDX_LUI || rom_idx == IDX_AUIPC) begin
      ctrl_c.legal   = 1'b1;
      ctrl_c.alu_sel = (rom_idx == IDX_LUI) ? ALU_COPYB : ALU_ADD;
      ctrl_c.a_sel   = (rom_idx == IDX_AUIPC);
      ctrl_c.b_sel   = 1'b1;
      ctrl_c.imm_sel = IMM_U;
      ctrl_c.reg_we  = 1'b1;
      ctrl_c.wb_sel  = WB_ALU;
    end else if (rom_idx == IDX_JAL || rom_idx == IDX_JALR) begin
      ctrl_c.legal    = 1'b1;
      ctrl_c.redirect = 1'b1;
      ctrl_c.a_sel    = (rom_idx == IDX_JAL);
      ctrl_c.b_sel    = 1'b1;
      ctrl_c.imm_sel  = (rom_idx == IDX_JAL) ? IMM_J : IMM_I;
      ctrl_c.reg_we   = 1'b1;
      ctrl_c.wb_sel   = WB_PC4;
    end else if (rom_idx >= IDX_BR_LO && rom_idx <= IDX_BR_HI) begin
      ctrl_c.legal    = 1'b1;
      ctrl_c.redirect = rom_idx[0];
      ctrl_c.a_sel    = 1'b1;
      ctrl_c.b_sel    = 1'b1;
      ctrl_c.imm_sel  = IMM_B;
      ctrl_c.br_un    = (rom_idx >= IDX_BLTU);
    end else if (rom_idx >= IDX_SB && rom_idx <= IDX_SW) begin
      ctrl_c.legal   = 1'b1;
      ctrl_c.b_sel   = 1'b1;
      ctrl_c.imm_sel = IMM_S;
      ctrl_c.mem_we  = (rom_idx == IDX_SB) ? 4'b0001 :
                       (rom_idx == IDX_SH) ? 4'b0011 : 4'b1111;
    end else if (rom_idx == IDX_NOP) begin
      ctrl_c.legal = 1'b1;
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// X-stage control expansion, W-stage control register, redirect kill and retired counter.
// Define CTRL_FORWARDING_EN to enable the rs1/rs2 forwarding selects (tied low otherwise).
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [IDX_W-1:0] rom_idx,
  input  logic             idx_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic [1:0]       pc_sel,
  output logic             flush,
  output logic [ALU_W-1:0] alu_sel,
  output logic             a_sel,
  output logic             b_sel,
  output logic [IMM_W-1:0] imm_sel,
  output logic             br_un,
  output logic [WE_W-1:0]  mem_we,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             w_reg_we,
  output logic [WB_W-1:0]  w_wb_sel,
  output logic [LD_W-1:0]  w_ld_type,
  output logic [REG_W-1:0] w_rd,
  output logic             w_illegal,
  output logic [CNT_W-1:0] instret
);

  ctrl_t            rom_c;
  w_ctrl_t          w_q, w_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             live_c, eff_c, redirect_c;

  control_rom u_rom (
    .rom_idx (rom_idx),
    .ctrl_c  (rom_c)
  );

  assign live_c     = idx_valid & ~kill_q;
  assign eff_c      = live_c & rom_c.legal;
  assign redirect_c = eff_c & rom_c.redirect;

  // X-stage controls; ineffective slots present the all-zero NOP word
  always_comb begin
    pc_sel  = {1'b0, redirect_c};
    flush   = redirect_c;
    alu_sel = '0;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    imm_sel = '0;
    br_un   = 1'b0;
    mem_we  = '0;
    if (eff_c) begin
      alu_sel = rom_c.alu_sel;
      a_sel   = rom_c.a_sel;
      b_sel   = rom_c.b_sel;
      imm_sel = rom_c.imm_sel;
      br_un   = rom_c.br_un;
      mem_we  = stall ? '0 : rom_c.mem_we;
    end
  end

  // Next state: everything holds under stall
  always_comb begin
    w_d       = w_q;
    kill_d    = kill_q;
    instret_d = instret_q;
    if (!stall) begin
      w_d         = '0;
      w_d.valid   = live_c;
      w_d.illegal = live_c & ~rom_c.legal;
      if (eff_c) begin
        w_d.reg_we  = rom_c.reg_we & (rd != '0);
        w_d.wb_sel  = rom_c.wb_sel;
        w_d.ld_type = rom_c.ld_type;
        w_d.rd      = rd;
      end
      kill_d    = redirect_c;
      instret_d = instret_q + CNT_W'(w_q.valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= '0;
      kill_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      w_q       <= w_d;
      kill_q    <= kill_d;
      instret_q <= instret_d;
    end
  end

  assign w_reg_we  = w_q.reg_we;
  assign w_wb_sel  = w_q.wb_sel;
  assign w_ld_type = w_q.ld_type;
  assign w_rd      = w_q.rd;
  assign w_illegal = w_q.illegal;
  assign instret   = instret_q;

`ifdef CTRL_FORWARDING_EN
  assign fwd_a = w_q.valid & w_q.reg_we & (w_q.rd == rs1);
  assign fwd_b = w_q.valid & w_q.reg_we & (w_q.rd == rs2);
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd_a     = 1'b0;
  assign fwd_b     = 1'b0;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: directed sequences plus random traffic,
// checked against an instruction-level reference model.
module tb_control_pipeline;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, stall, idx_valid;
  logic [5:0]       rom_idx;
  logic [4:0]       rs1, rs2, rd;
  logic [1:0]       pc_sel;
  logic             flush, a_sel, b_sel, br_un, fwd_a, fwd_b;
  logic [3:0]       alu_sel, mem_we;
  logic [2:0]       imm_sel, w_ld_type;
  logic             w_reg_we, w_illegal;
  logic [1:0]       w_wb_sel;
  logic [4:0]       w_rd;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  control_pipeline #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .rom_idx(rom_idx), .idx_valid(idx_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .pc_sel(pc_sel), .flush(flush),
    .alu_sel(alu_sel), .a_sel(a_sel), .b_sel(b_sel), .imm_sel(imm_sel), .br_un(br_un),
    .mem_we(mem_we), .fwd_a(fwd_a), .fwd_b(fwd_b), .w_reg_we(w_reg_we),
    .w_wb_sel(w_wb_sel), .w_ld_type(w_ld_type), .w_rd(w_rd), .w_illegal(w_illegal),
    .instret(instret)
  );

  typedef struct {
    logic redir; logic [3:0] alu; logic a; logic b; logic [2:0] imm; logic br_un;
    logic [3:0] st_mask; logic wr; logic [1:0] wb; logic [2:0] ld;
  } dec_t;

  typedef struct {
    logic valid; logic we; logic [1:0] wb; logic [2:0] ld; logic [4:0] rd; logic ill;
  } wrec_t;

  typedef struct {
    logic chk_x; logic [1:0] pc_sel; logic flush; logic [3:0] alu; logic a; logic b;
    logic [2:0] imm; logic br_un; logic [3:0] mem_we; logic fwd_a; logic fwd_b;
    wrec_t w; logic [31:0] instret;
  } exp_t;

  exp_t        sb_q[$];
  wrec_t       m_w;
  logic        m_dead;
  logic [31:0] m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  // Instruction semantics straight from the index table
  function automatic dec_t ref_decode(int i);
    dec_t r;
    int   ops[9];
    ops = '{0, 2, 3, 4, 5, 6, 7, 8, 9};
    r = '{default: '0};
    if (i < 10) begin
      r.alu = 4'(i); r.wr = 1; r.wb = 1;
    end else if (i < 15) begin
      r.b = 1; r.imm = 0; r.wr = 1; r.wb = 0; r.ld = 3'(i - 9);
    end else if (i < 24) begin
      r.alu = 4'(ops[i-15]); r.b = 1; r.imm = 0; r.wr = 1; r.wb = 1;
    end else if (i == 24) begin
      r.alu = 10; r.b = 1; r.imm = 3; r.wr = 1; r.wb = 1;
    end else if (i == 25) begin
      r.a = 1; r.b = 1; r.imm = 3; r.wr = 1; r.wb = 1;
    end else if (i == 26) begin
      r.a = 1; r.b = 1; r.imm = 4; r.wr = 1; r.wb = 2; r.redir = 1;
    end else if (i == 27) begin
      r.b = 1; r.imm = 0; r.wr = 1; r.wb = 2; r.redir = 1;
    end else if (i < 40) begin
      r.a = 1; r.b = 1; r.imm = 2; r.br_un = (i >= 36); r.redir = (i % 2 == 1);
    end else if (i < 43) begin
      r.b = 1; r.imm = 1;
      r.st_mask = (i == 40) ? 4'b0001 : (i == 41) ? 4'b0011 : 4'b1111;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w    = '{default: '0};
    m_dead = 1'b0;
    m_cnt  = '0;
  endtask

  // One clock of stimulus: drive, queue the expected response, advance the model
  task automatic cyc(input logic r, input logic s, input logic v, input int idx,
                     input int a, input int b, input int d);
    exp_t  e;
    dec_t  dc;
    logic  live, legal, eff;
    wrec_t nw;
    rst = r; stall = s; idx_valid = v;
    rom_idx = 6'(idx); rs1 = 5'(a); rs2 = 5'(b); rd = 5'(d);
    dc    = ref_decode(idx);
    live  = v && !m_dead;
    legal = (idx <= 42) || (idx == 63);
    eff   = live && legal;
    e.chk_x   = eff;
    e.pc_sel  = {1'b0, eff && dc.redir};
    e.flush   = eff && dc.redir;
    e.alu = dc.alu; e.a = dc.a; e.b = dc.b; e.imm = dc.imm; e.br_un = dc.br_un;
    e.mem_we  = (eff && !s) ? dc.st_mask : 4'b0;
`ifdef CTRL_FORWARDING_EN
    e.fwd_a = m_w.valid && m_w.we && (m_w.rd == 5'(a));
    e.fwd_b = m_w.valid && m_w.we && (m_w.rd == 5'(b));
`else
    e.fwd_a = 1'b0;
    e.fwd_b = 1'b0;
`endif
    e.w       = m_w;
    e.instret = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else if (!s) begin
      nw       = '{default: '0};
      nw.valid = live;
      nw.ill   = live && !legal;
      if (eff) begin
        nw.we = dc.wr && (d != 0); nw.wb = dc.wb; nw.ld = dc.ld; nw.rd = 5'(d);
      end
      m_cnt  = m_cnt + (m_w.valid ? 32'd1 : 32'd0);
      m_w    = nw;
      m_dead = eff && dc.redir;
    end
  endtask

  // Monitor: one expected response per clock, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("mem_we", 32'(mem_we), 32'(e.mem_we));
        chk("fwd_a", 32'(fwd_a), 32'(e.fwd_a));
        chk("fwd_b", 32'(fwd_b), 32'(e.fwd_b));
        chk("w_reg_we", 32'(w_reg_we), 32'(e.w.we));
        chk("w_wb_sel", 32'(w_wb_sel), 32'(e.w.wb));
        chk("w_ld_type", 32'(w_ld_type), 32'(e.w.ld));
        chk("w_rd", 32'(w_rd), 32'(e.w.rd));
        chk("w_illegal", 32'(w_illegal), 32'(e.w.ill));
        chk("instret", instret, e.instret);
        if (e.chk_x) begin
          chk("alu_sel", 32'(alu_sel), 32'(e.alu));
          chk("a_sel", 32'(a_sel), 32'(e.a));
          chk("b_sel", 32'(b_sel), 32'(e.b));
          chk("imm_sel", 32'(imm_sel), 32'(e.imm));
          chk("br_un", 32'(br_un), 32'(e.br_un));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int sel, idx;
    rst = 1; stall = 1; idx_valid = 0; rom_idx = 0; rs1 = 0; rs2 = 0; rd = 0;
    @(posedge clk);
    #1;
    model_reset();
    // reset held with stall, then release
    cyc(1, 1, 1, 26, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 3);
    cyc(0, 0, 0, 63, 0, 0, 0);
    // add x5 then sub reading x5
    cyc(0, 0, 1, 0, 1, 2, 5);
    cyc(0, 0, 1, 1, 5, 5, 6);
    cyc(0, 0, 1, 63, 0, 0, 0);
    // taken beq then wrong-path sw
    cyc(0, 0, 1, 29, 1, 2, 0);
    cyc(0, 0, 1, 42, 1, 2, 0);
    cyc(0, 0, 1, 63, 0, 0, 0);
    // back-to-back jal, then a normal instruction
    cyc(0, 0, 1, 26, 0, 0, 1);
    cyc(0, 0, 1, 26, 0, 0, 1);
    cyc(0, 0, 1, 15, 1, 0, 2);
    cyc(0, 0, 1, 63, 0, 0, 0);
    // illegal index
    cyc(0, 0, 1, 50, 0, 0, 4);
    cyc(0, 0, 1, 63, 0, 0, 0);
    cyc(0, 0, 1, 63, 0, 0, 0);
    // lw under a 3-cycle stall, then a stalled store
    cyc(0, 1, 1, 12, 1, 0, 7);
    cyc(0, 1, 1, 12, 1, 0, 7);
    cyc(0, 1, 1, 12, 1, 0, 7);
    cyc(0, 0, 1, 12, 1, 0, 7);
    cyc(0, 0, 1, 63, 7, 7, 0);
    cyc(0, 1, 1, 41, 1, 2, 0);
    cyc(0, 0, 1, 41, 1, 2, 0);
    // redirect stalled, then reset discards the pending kill
    cyc(0, 1, 1, 27, 0, 0, 3);
    cyc(0, 0, 1, 27, 0, 0, 3);
    cyc(1, 0, 1, 10, 0, 0, 3);
    cyc(0, 0, 1, 26, 0, 0, 3);
    cyc(0, 0, 1, 63, 0, 0, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      idx = int'($urandom_range(43, 62));
      else if (sel == 1) idx = 63;
      else               idx = int'($urandom_range(0, 42));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 9) != 0), idx, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    cyc(0, 0, 0, 63, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
